// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: round-robin merge of a read and a write memory port onto one SRAM.
// Define MEM_RW_ARBITER_PERF_EN to add grant/stall performance counters.
`timescale 1ns/1ps

package mem_rw_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        write;
  } mem_req_chan_t;

  typedef struct packed {
    logic          q_valid;
    mem_req_chan_t q;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } mem_rsp_chan_t;

  typedef struct packed {
    logic          q_ready;
    mem_rsp_chan_t p;
  } mem_rsp_t;

endpackage

module mem_rw_arbiter #(
  parameter type mem_req_t = mem_rw_arbiter_pkg::mem_req_t,
  parameter type mem_rsp_t = mem_rw_arbiter_pkg::mem_rsp_t,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords = 1024,
  parameter int unsigned SramLatency = 1,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned SramAw = $clog2(NumWords),
  localparam int unsigned Off = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  mem_req_t             mem_req_i [2],
  output mem_rsp_t             mem_rsp_o [2],
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [SramAw-1:0]    sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
`ifdef MEM_RW_ARBITER_PERF_EN
  input  logic                 perf_clr_i,
  output logic [31:0]          perf_gnt_o [2],
  output logic [31:0]          perf_stall_o,
`endif
  input  logic [DataWidth-1:0] sram_rdata_i
);

  logic       rr_ptr;
  logic [1:0] valid;
  logic [1:0] grant;
  logic       gnt_port;
  logic       gnt_any;
  mem_req_t   sel;

  logic [SramLatency-1:0] pipe_vld;
  logic [SramLatency-1:0] pipe_port;
  logic [SramLatency-1:0] pipe_we;

  logic rsp_vld;
  logic rsp_port;
  logic rsp_we;

  always_comb begin
    valid = {mem_req_i[1].q_valid, mem_req_i[0].q_valid};
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    gnt_port = grant[1];
    gnt_any  = |grant;
  end

  // Idle cycles drive all SRAM fields low, not just the chip enable.
  always_comb begin
    sel          = mem_req_i[gnt_port];
    sram_req_o   = gnt_any;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_any) begin
      sram_we_o    = sel.q.write;
      sram_addr_o  = sel.q.addr[Off +: SramAw];
      sram_wdata_o = sel.q.data;
      sram_be_o    = sel.q.strb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= 1'b0;
    end else if (gnt_any) begin
      rr_ptr <= ~gnt_port;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld  <= '0;
      pipe_port <= '0;
      pipe_we   <= '0;
    end else begin
      pipe_vld[0]  <= gnt_any;
      pipe_port[0] <= gnt_port;
      pipe_we[0]   <= sram_we_o;
      for (int i = 1; i < SramLatency; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_port[i] <= pipe_port[i-1];
        pipe_we[i]   <= pipe_we[i-1];
      end
    end
  end

  assign rsp_vld  = pipe_vld[SramLatency-1];
  assign rsp_port = pipe_port[SramLatency-1];
  assign rsp_we   = pipe_we[SramLatency-1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rsp_o[i]         = '0;
      mem_rsp_o[i].q_ready = grant[i];
      if (rsp_vld && (rsp_port == 1'(i))) begin
        mem_rsp_o[i].p.valid = 1'b1;
        mem_rsp_o[i].p.data  = rsp_we ? '0 : sram_rdata_i;
      end
    end
  end

`ifdef MEM_RW_ARBITER_PERF_EN
  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_gnt_o[0] <= '0;
      perf_gnt_o[1] <= '0;
      perf_stall_o  <= '0;
    end else if (perf_clr_i) begin
      perf_gnt_o[0] <= '0;
      perf_gnt_o[1] <= '0;
      perf_stall_o  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i] && (perf_gnt_o[i] != '1)) begin
          perf_gnt_o[i] <= perf_gnt_o[i] + 32'd1;
        end
      end
      if ((&valid) && (perf_stall_o != '1)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

  logic unused_addr;
  assign unused_addr = ^{mem_req_i[0].q.addr, mem_req_i[1].q.addr};

  for (genvar p = 0; p < 2; p++) begin : g_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_req_i[p].q_valid && !mem_rsp_o[p].q_ready
      |=> mem_req_i[p].q_valid && $stable(mem_req_i[p].q));
    if (AddrWidth > Off + SramAw) begin : g_hi
      assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_req_i[p].q_valid
        |-> mem_req_i[p].q.addr[AddrWidth-1:Off+SramAw] == '0);
    end
  end

endmodule
